// File: rtl/aes_cipher_iter.sv
// Iterative AES-128/192/256 core: one cipher round per clock over a pre-expanded key schedule.
// A single shared round datapath serves both directions; mode is latched per block.
module aes_cipher_iter #(
  parameter  int NK = 4,
  localparam int NR = NK + 6,
  localparam int KW = 128 * (NR + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          decrypt,
  input  logic [0:127]  in,
  input  logic [0:KW-1] words,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [0:127]  out,
  output logic          busy
);

  if (NK != 4 && NK != 6 && NK != 8) begin : g_bad_nk
    $error("aes_cipher_iter: NK must be 4, 6 or 8");
  end

  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

  fsm_t         fsm, fsm_n;
  logic [3:0]   round, round_n;
  logic [0:127] state, state_n;
  logic         mode_q, mode_n;
  logic [0:127] out_n;
  logic         out_valid_n, in_ready_n;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc, p;
    acc = '0;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  // Multiplicative inverse as a^254 (2+4+...+128); maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r, p;
    r = 8'h01;
    p = a;
    for (int i = 0; i < 7; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = ginv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    logic [7:0] b;
    b = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    return ginv(b);
  endfunction

  function automatic logic [0:127] sub_bytes(input logic [0:127] s, input logic inv);
    logic [0:127] o;
    for (int i = 0; i < 16; i++)
      o[8*i +: 8] = inv ? inv_sbox(s[8*i +: 8]) : sbox(s[8*i +: 8]);
    return o;
  endfunction

  // Byte 4c+r sits in row r of column c; forward shifts rows left, inverse shifts right.
  function automatic logic [0:127] shift_rows(input logic [0:127] s, input logic inv);
    logic [0:127] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[8*(4*c+r) +: 8] = inv ? s[8*(4*((c+4-r)%4)+r) +: 8] : s[8*(4*((c+r)%4)+r) +: 8];
    return o;
  endfunction

  function automatic logic [0:127] mix_columns(input logic [0:127] s, input logic inv);
    logic [0:127] o;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[32*c +: 8];
      a1 = s[32*c+8 +: 8];
      a2 = s[32*c+16 +: 8];
      a3 = s[32*c+24 +: 8];
      if (inv)
        o[32*c +: 32] = {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
                         gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
                         gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
                         gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
      else
        o[32*c +: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                         a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                         a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                         xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return o;
  endfunction

  int           kidx;
  logic [0:127] rkey, k0, enc_sr, enc_next, dec_t, dec_next, rnd_out;
  logic         last;

  // Decrypt walks the schedule backwards, so round r uses key NR-r.
  always_comb begin
    kidx     = mode_q ? NR - int'(round) : int'(round);
    rkey     = words[128*kidx +: 128];
    k0       = decrypt ? words[128*NR +: 128] : words[0 +: 128];
    last     = (round == 4'(NR));
    enc_sr   = shift_rows(sub_bytes(state, 1'b0), 1'b0);
    enc_next = (last ? enc_sr : mix_columns(enc_sr, 1'b0)) ^ rkey;
    dec_t    = sub_bytes(shift_rows(state, 1'b1), 1'b1) ^ rkey;
    dec_next = last ? dec_t : mix_columns(dec_t, 1'b1);
    rnd_out  = mode_q ? dec_next : enc_next;
  end

  always_comb begin
    fsm_n       = fsm;
    round_n     = round;
    state_n     = state;
    mode_n      = mode_q;
    out_n       = out;
    out_valid_n = out_valid;
    in_ready_n  = in_ready;
    case (fsm)
      IDLE: begin
        if (in_valid && in_ready) begin
          mode_n     = decrypt;
          state_n    = in ^ k0;
          round_n    = 4'd1;
          in_ready_n = 1'b0;
          fsm_n      = ROUND;
        end
      end
      ROUND: begin
        state_n = rnd_out;
        if (last) begin
          out_n       = rnd_out;
          out_valid_n = 1'b1;
          fsm_n       = DONE;
        end else begin
          round_n = round + 4'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_n = 1'b0;
          in_ready_n  = 1'b1;
          round_n     = '0;
          fsm_n       = IDLE;
        end
      end
      default: fsm_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm       <= IDLE;
      round     <= '0;
      state     <= '0;
      mode_q    <= 1'b0;
      out       <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      fsm       <= fsm_n;
      round     <= round_n;
      state     <= state_n;
      mode_q    <= mode_n;
      out       <= out_n;
      out_valid <= out_valid_n;
      in_ready  <= in_ready_n;
    end
  end

  assign busy = (fsm != IDLE);

endmodule

// File: tb/tb_aes_cipher_iter.sv
// Bench for aes_cipher_iter: NK=4/6/8 instances, known-answer table, backpressure,
// mid-block reset and back-to-back blocks checked against an independent AES model.
module tb_aes_cipher_iter;

  localparam logic [0:127] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [0:127] CT4 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [0:127] CT6 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [0:127] CT8 = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic               clk, rst, decrypt, out_ready;
  logic [0:127]       din;
  logic               in_valid [3];
  logic               in_ready [3];
  logic               out_valid [3];
  logic               busy [3];
  logic [0:127]       dout [3];
  logic [0:128*11-1]  w4;
  logic [0:128*13-1]  w6;
  logic [0:128*15-1]  w8;

  aes_cipher_iter #(.NK(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .decrypt(decrypt),
    .in(din), .words(w4), .out_valid(out_valid[0]), .out_ready(out_ready), .out(dout[0]),
    .busy(busy[0]));
  aes_cipher_iter #(.NK(6)) dut6 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .decrypt(decrypt),
    .in(din), .words(w6), .out_valid(out_valid[1]), .out_ready(out_ready), .out(dout[1]),
    .busy(busy[1]));
  aes_cipher_iter #(.NK(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .decrypt(decrypt),
    .in(din), .words(w8), .out_valid(out_valid[2]), .out_ready(out_ready), .out(dout[2]),
    .busy(busy[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct { int g; logic [0:127] exp; } exp_t;
  typedef struct { int g; bit dec; logic [0:127] din; logic [0:127] exp; } vec_t;

  exp_t       sbq[$];
  vec_t       vecs[6];
  int         total, bad, edges;
  int         accept_edge [3];
  bit         accepted [3];
  bit         prev_ov [3];
  logic [7:0] sb [256];
  logic [7:0] isb [256];

  function automatic int nr_of(input int g);
    return 10 + 2 * g;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int s);
    return 8'((v << s) | (v >> (8 - s)));
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) r = r ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return r;
  endfunction

  // S-box built by walking generator 3 and its inverse together (log/antilog style).
  task automatic init_tables();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
    for (int i = 0; i < 256; i++) isb[sb[i]] = 8'(i);
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] t);
    return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
  endfunction

  function automatic logic [0:128*15-1] expand_key(input logic [0:255] key, input int nk);
    logic [31:0]       w [60];
    logic [31:0]       t;
    logic [7:0]        rc;
    logic [0:128*15-1] ks;
    ks = '0;
    rc = 8'h01;
    for (int i = 0; i < 4 * (nk + 7); i++) begin
      if (i < nk) begin
        w[i] = key[32*i +: 32];
      end else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = gm(rc, 8'h02);
        end else if (nk > 6 && i % nk == 4) begin
          t = sub_word(t);
        end
        w[i] = w[i-nk] ^ t;
      end
      ks[32*i +: 32] = w[i];
    end
    return ks;
  endfunction

  function automatic logic [0:127] model_cipher(input logic [0:127] blk, input logic [0:128*15-1] ks,
                                                input int nr, input bit dec);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [0:127] o;
    for (int i = 0; i < 16; i++) s[i] = blk[8*i +: 8] ^ ks[128*(dec ? nr : 0) + 8*i +: 8];
    if (!dec) begin
      for (int r = 1; r <= nr; r++) begin
        for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
        for (int c = 0; c < 4; c++)
          for (int w = 0; w < 4; w++) s[4*c+w] = t[4*((c+w)%4)+w];
        if (r < nr) begin
          for (int c = 0; c < 4; c++) begin
            a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
            s[4*c]   = gm(a0, 2) ^ gm(a1, 3) ^ a2 ^ a3;
            s[4*c+1] = a0 ^ gm(a1, 2) ^ gm(a2, 3) ^ a3;
            s[4*c+2] = a0 ^ a1 ^ gm(a2, 2) ^ gm(a3, 3);
            s[4*c+3] = gm(a0, 3) ^ a1 ^ a2 ^ gm(a3, 2);
          end
        end
        for (int i = 0; i < 16; i++) s[i] = s[i] ^ ks[128*r + 8*i +: 8];
      end
    end else begin
      for (int r = nr - 1; r >= 0; r--) begin
        for (int c = 0; c < 4; c++)
          for (int w = 0; w < 4; w++) t[4*((c+w)%4)+w] = s[4*c+w];
        for (int i = 0; i < 16; i++) s[i] = isb[t[i]] ^ ks[128*r + 8*i +: 8];
        if (r > 0) begin
          for (int c = 0; c < 4; c++) begin
            a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
            s[4*c]   = gm(a0, 14) ^ gm(a1, 11) ^ gm(a2, 13) ^ gm(a3, 9);
            s[4*c+1] = gm(a0, 9) ^ gm(a1, 14) ^ gm(a2, 11) ^ gm(a3, 13);
            s[4*c+2] = gm(a0, 13) ^ gm(a1, 9) ^ gm(a2, 14) ^ gm(a3, 11);
            s[4*c+3] = gm(a0, 11) ^ gm(a1, 13) ^ gm(a2, 9) ^ gm(a3, 14);
          end
        end
      end
    end
    for (int i = 0; i < 16; i++) o[8*i +: 8] = s[i];
    return o;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic timeoutFail(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: bound expired at edge %0d, required DUT event", name, edges);
  endtask

  // Called at a negedge after inputs are set: pops results on handshakes that the
  // coming posedge will complete, then notes accepts and output latency.
  task automatic tick();
    bit   acc [3];
    exp_t e;
    for (int g = 0; g < 3; g++) begin
      acc[g] = in_valid[g] && in_ready[g];
      checkOutput($sformatf("valid_while_ready%0d", g), out_valid[g] && in_ready[g], 0);
      if (out_valid[g] && out_ready) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_output%0d: got %h required no output", g, dout[g]);
        end else begin
          e = sbq.pop_front();
          checkOutput("result_dut", g, e.g);
          checkOutput($sformatf("result%0d", g), dout[g], e.exp);
        end
      end
    end
    @(posedge clk);
    edges++;
    for (int g = 0; g < 3; g++)
      if (acc[g]) begin
        accept_edge[g] = edges;
        accepted[g]    = 1'b1;
      end
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      if (out_valid[g] && !prev_ov[g])
        checkOutput($sformatf("latency%0d", g), edges - accept_edge[g], nr_of(g));
      prev_ov[g] = out_valid[g];
    end
  endtask

  task automatic applyStimulus(input int g, input bit dec, input logic [0:127] data,
                               input logic [0:127] exp);
    int n;
    in_valid[g] = 1'b1;
    decrypt     = dec;
    din         = data;
    accepted[g] = 1'b0;
    n = 0;
    while (!accepted[g] && n < 50) begin
      tick();
      n++;
    end
    if (!accepted[g]) timeoutFail($sformatf("accept_timeout%0d", g));
    else sbq.push_back('{g, exp});
    in_valid[g] = 1'b0;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 60) begin
      tick();
      n++;
    end
    if (sbq.size() != 0) begin
      timeoutFail("drain_timeout");
      sbq.delete();
    end
  endtask

  initial begin
    logic [0:128*15-1] ks;
    logic [0:255]      key;
    logic [0:127]      blk, exp;
    int                prev_acc, n;

    total = 0;
    bad   = 0;
    edges = 0;
    for (int g = 0; g < 3; g++) begin
      in_valid[g]    = 1'b0;
      accepted[g]    = 1'b0;
      prev_ov[g]     = 1'b0;
      accept_edge[g] = 0;
    end
    init_tables();
    key = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    ks = expand_key(key, 4); w4 = ks[0:128*11-1];
    ks = expand_key(key, 6); w6 = ks[0:128*13-1];
    ks = expand_key(key, 8); w8 = ks;
    vecs[0] = '{0, 1'b0, PT, CT4};
    vecs[1] = '{1, 1'b0, PT, CT6};
    vecs[2] = '{2, 1'b0, PT, CT8};
    vecs[3] = '{0, 1'b1, CT4, PT};
    vecs[4] = '{1, 1'b1, CT6, PT};
    vecs[5] = '{2, 1'b1, CT8, PT};
    rst = 1'b1; decrypt = 1'b0; din = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    for (int g = 0; g < 3; g++) begin
      checkOutput($sformatf("reset_in_ready%0d", g), in_ready[g], 1);
      checkOutput($sformatf("reset_out_valid%0d", g), out_valid[g], 0);
      checkOutput($sformatf("reset_out%0d", g), dout[g], 0);
      checkOutput($sformatf("reset_busy%0d", g), busy[g], 0);
    end

    $display("[TB] known-answer table");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].g, vecs[i].dec, vecs[i].din, vecs[i].exp);
      checkOutput($sformatf("busy_after_accept%0d", i), busy[vecs[i].g], 1);
      checkOutput($sformatf("in_ready_after_accept%0d", i), in_ready[vecs[i].g], 0);
      waitDrain();
    end

    $display("[TB] backpressure");
    out_ready = 1'b0;
    applyStimulus(0, 1'b0, PT, CT4);
    n = 0;
    while (!out_valid[0] && n < 40) begin
      tick();
      n++;
    end
    if (!out_valid[0]) timeoutFail("bp_out_valid_timeout");
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_out_stable", dout[0], CT4);
      checkOutput("bp_out_valid", out_valid[0], 1);
      checkOutput("bp_in_ready", in_ready[0], 0);
      in_valid[0] = (i % 2 == 0);
      din = 128'hdeadbeef_cafef00d_01234567_89abcdef;
      tick();
    end
    in_valid[0] = 1'b0;
    out_ready = 1'b1;
    tick();
    checkOutput("bp_release_in_ready", in_ready[0], 1);
    checkOutput("bp_release_out_valid", out_valid[0], 0);
    checkOutput("bp_release_busy", busy[0], 0);
    checkOutput("bp_out_kept", dout[0], CT4);
    applyStimulus(0, 1'b1, CT4, PT);
    waitDrain();

    $display("[TB] reset mid-block");
    applyStimulus(0, 1'b0, PT, CT4);
    repeat (4) tick();
    rst = 1'b1;
    void'(sbq.pop_back());
    tick();
    rst = 1'b0;
    checkOutput("mid_rst_in_ready", in_ready[0], 1);
    checkOutput("mid_rst_out_valid", out_valid[0], 0);
    checkOutput("mid_rst_out", dout[0], 0);
    checkOutput("mid_rst_busy", busy[0], 0);
    repeat (20) tick();
    applyStimulus(0, 1'b0, PT, CT4);
    waitDrain();

    $display("[TB] back-to-back random blocks");
    key = {$urandom(), $urandom(), $urandom(), $urandom(), 128'h0};
    ks = expand_key(key, 4);
    w4 = ks[0:128*11-1];
    prev_acc = 0;
    for (int k = 0; k < 4; k++) begin
      blk = {$urandom(), $urandom(), $urandom(), $urandom()};
      exp = model_cipher(blk, ks, 10, (k % 2) == 1);
      applyStimulus(0, (k % 2) == 1, blk, exp);
      if (k > 0) checkOutput($sformatf("b2b_spacing%0d", k), accept_edge[0] - prev_acc, 12);
      prev_acc = accept_edge[0];
      in_valid[0] = (k < 3);
    end
    in_valid[0] = 1'b0;
    waitDrain();
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
